// File: rtl/servo_pwm_multi_if.sv
// Position write port of servo_pwm_multi: valid/ready handshake carrying
// a channel index and a requested servo position.
interface servo_pwm_multi_if #(
  parameter int CH_W  = 2,
  parameter int POS_W = 8
);
  logic             wr_valid;
  logic             wr_ready;
  logic [CH_W-1:0]  wr_ch;
  logic [POS_W-1:0] wr_pos;

  modport master (output wr_valid, output wr_ch, output wr_pos, input wr_ready);
  modport slave  (input wr_valid, input wr_ch, input wr_pos, output wr_ready);
endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: shared frame counter, per-channel positions,
// widths recomputed each frame and committed at the wrap. Option: SERVO_SLEW_LIMIT_EN.
module servo_pwm_multi #(
  parameter int CHANNELS      = 4,
  parameter int PERIOD_CYCLES = 1_000_000,
  parameter int MIN_PULSE     = 25_000,
  parameter int MAX_PULSE     = 125_000,
  parameter int CNT_W         = 20,
  parameter int POS_W         = 8,
  parameter int POS_MAX       = 100,
  parameter int SLEW_STEP     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  servo_pwm_multi_if.slave    wr,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                frame_start
);
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PROD_W = CNT_W + POS_W;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CH_W-1:0]  LAST_IDX  = CH_W'(CHANNELS - 1);
  localparam logic [POS_W-1:0] POS_TOP   = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_MID   = POS_W'(POS_MAX / 2);
  localparam logic [CNT_W-1:0] PULSE_MID = CNT_W'((MIN_PULSE + MAX_PULSE) / 2);

  if ((PERIOD_CYCLES <= CHANNELS + 1) || ((64'd1 << CNT_W) <= 64'(PERIOD_CYCLES)) ||
      (SLEW_STEP < 1)) begin : g_bad_cfg
    $error("servo_pwm_multi: inconsistent parameters");
  end

  function automatic logic [CNT_W-1:0] pulse_of(input logic [POS_W-1:0] pos);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(MAX_PULSE - MIN_PULSE) * PROD_W'(pos);
    return CNT_W'(MIN_PULSE) + CNT_W'(prod / PROD_W'(POS_MAX));
  endfunction

  typedef enum logic [0:0] {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [CH_W-1:0]     idx_r, idx_s;
  logic [CNT_W-1:0]    cnt_r;
  logic                frame_start_r;
  logic                wr_ready_r;
  logic                wr_fire_s;
  logic [CHANNELS-1:0] pwm_r;
  logic [CHANNELS-1:0] armed_r;
  logic [POS_W-1:0]    target_r [CHANNELS];
  logic [CNT_W-1:0]    shadow_r [CHANNELS];
  logic [CNT_W-1:0]    active_r [CHANNELS];
  logic [POS_W-1:0]    pos_s;

  assign frame_start = frame_start_r;
  assign pwm_out     = pwm_r;
  assign wr.wr_ready = wr_ready_r;
  assign wr_fire_s   = wr.wr_valid && wr_ready_r;

  // Frame counter and the strobe marking its zero cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r         <= '0;
      frame_start_r <= 1'b0;
    end else begin
      cnt_r         <= (cnt_r == LAST_CNT) ? '0 : cnt_r + CNT_W'(1);
      frame_start_r <= (cnt_r == LAST_CNT);
    end
  end

  // Calculation FSM state, channel index and write-port readiness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      wr_ready_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      wr_ready_r <= (state_s == IDLE);
    end
  end

  // Next-state logic: one channel per CALC cycle, starting at the frame's zero count.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (cnt_r == '0) begin
          state_s = CALC;
          idx_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (idx_r == LAST_IDX) begin
          state_s = IDLE;
          idx_s   = '0;
        end else begin
          idx_s = idx_r + CH_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = '0;
      end
    endcase
  end

  // Target positions: clamped on write, out-of-range channels silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) target_r[i] <= POS_MID;
    end else if (wr_fire_s && (int'(wr.wr_ch) < CHANNELS)) begin
      target_r[wr.wr_ch] <= (wr.wr_pos > POS_TOP) ? POS_TOP : wr.wr_pos;
    end
  end

`ifdef SERVO_SLEW_LIMIT_EN
  function automatic logic [POS_W-1:0] slew_toward(input logic [POS_W-1:0] cur,
                                                   input logic [POS_W-1:0] tgt);
    logic [POS_W-1:0] step;
    logic [POS_W-1:0] diff;
    step = POS_W'(SLEW_STEP);
    if (tgt > cur) begin
      diff = tgt - cur;
      return cur + ((diff > step) ? step : diff);
    end else begin
      diff = cur - tgt;
      return cur - ((diff > step) ? step : diff);
    end
  endfunction

  logic [POS_W-1:0] cur_r [CHANNELS];

  assign pos_s = slew_toward(cur_r[idx_r], target_r[idx_r]);

  // Rate-limited current position, advanced once per frame during CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) cur_r[i] <= POS_MID;
    end else if (state_r == CALC) begin
      cur_r[idx_r] <= pos_s;
    end
  end
`else
  assign pos_s = target_r[idx_r];
`endif

  // Shadow widths fill during CALC; active widths only change at the frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_r[i] <= PULSE_MID;
        active_r[i] <= PULSE_MID;
      end
    end else begin
      if (state_r == CALC) shadow_r[idx_r] <= pulse_of(pos_s);
      if (cnt_r == LAST_CNT) begin
        for (int i = 0; i < CHANNELS; i++) active_r[i] <= shadow_r[i];
      end
    end
  end

  // Outputs; armed keeps a re-enabled channel quiet until the next frame begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_r   <= '0;
      armed_r <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_r[i] <= en[i] && armed_r[i] && (cnt_r < active_r[i]);
        if (!en[i]) armed_r[i] <= 1'b0;
        else if (cnt_r == LAST_CNT) armed_r[i] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi: frame-level reference model of
// targets, committed widths, enables and handshake timing.
`timescale 1ns/1ps
module tb_servo_pwm_multi;
  localparam int CH   = 4;
  localparam int PER  = 1000;
  localparam int MINP = 50;
  localparam int MAXP = 150;
  localparam int PMAX = 100;
  localparam int STEP = 2;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] en;
  logic [CH-1:0] pwm_out;
  logic          frame_start;

  servo_pwm_multi_if #(.CH_W(2), .POS_W(8)) wr_bus ();

  servo_pwm_multi #(
    .CHANNELS(CH), .PERIOD_CYCLES(PER), .MIN_PULSE(MINP), .MAX_PULSE(MAXP),
    .CNT_W(20), .POS_W(8), .POS_MAX(PMAX), .SLEW_STEP(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr(wr_bus),
    .pwm_out(pwm_out), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int bc;
  bit fresh;
  int tgt [CH];
  int cur [CH];
  int calc_w [CH];
  int act_w [CH];
  int exp_cnt [CH];
  int hi_cnt [CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input int p);
    return MINP + ((MAXP - MINP) * p) / PMAX;
  endfunction

  // Write port is busy during the CHANNELS calculation cycles after each frame start.
  function automatic bit ready_m();
    return !(bc >= 1 && bc <= CH) && !(fresh && bc == 0);
  endfunction

  task automatic model_reset();
    bc = 0;
    fresh = 1'b1;
    for (int i = 0; i < CH; i++) begin
      tgt[i] = PMAX / 2;
      cur[i] = PMAX / 2;
      calc_w[i] = (MINP + MAXP) / 2;
      act_w[i] = (MINP + MAXP) / 2;
      exp_cnt[i] = 0;
      hi_cnt[i] = 0;
    end
  endtask

  task automatic tick();
    if (wr_bus.wr_valid && ready_m())
      tgt[wr_bus.wr_ch] = (int'(wr_bus.wr_pos) > PMAX) ? PMAX : int'(wr_bus.wr_pos);
    if (bc == 0) begin
      for (int i = 0; i < CH; i++) begin
`ifdef SERVO_SLEW_LIMIT_EN
        if (tgt[i] > cur[i]) cur[i] += (tgt[i] - cur[i] > STEP) ? STEP : tgt[i] - cur[i];
        else                 cur[i] -= (cur[i] - tgt[i] > STEP) ? STEP : cur[i] - tgt[i];
`else
        cur[i] = tgt[i];
`endif
        calc_w[i] = width_of(cur[i]);
      end
    end
    if (bc == PER - 1) begin
      for (int i = 0; i < CH; i++) act_w[i] = calc_w[i];
    end
    @(posedge clk);
    #1;
    bc = (bc + 1) % PER;
    fresh = 1'b0;
    if (bc == 0) begin
      for (int i = 0; i < CH; i++) begin
        chk($sformatf("pulse_len_ch%0d", i), 32'(hi_cnt[i]), 32'(exp_cnt[i]));
        hi_cnt[i] = 0;
        exp_cnt[i] = en[i] ? act_w[i] : 0;
      end
    end
    chk("frame_start", 32'(frame_start), 32'(bc == 0));
    chk("wr_ready", 32'(wr_bus.wr_ready), 32'(ready_m()));
    if (bc == 1) begin
      for (int i = 0; i < CH; i++)
        chk($sformatf("pulse_start_ch%0d", i), 32'(pwm_out[i]), 32'(exp_cnt[i] > 0));
    end
    for (int i = 0; i < CH; i++) hi_cnt[i] += int'(pwm_out[i]);
  endtask

  task automatic run_to(input int c);
    while (bc != c) tick();
  endtask

  task automatic run_frames(input int n);
    repeat (n) begin
      tick();
      run_to(0);
    end
  endtask

  task automatic write_pos(input int ch, input int pos, output int waits);
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_ch = 2'(ch);
    wr_bus.wr_pos = 8'(pos);
    waits = 0;
    while (!ready_m() && waits < 20) begin
      tick();
      waits++;
    end
    tick();
    wr_bus.wr_valid = 1'b0;
  endtask

  task automatic set_en(input int ch, input bit v);
    if (!v && exp_cnt[ch] > bc) exp_cnt[ch] = bc;
    en[ch] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pwm_out", 32'(pwm_out), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_wr_ready", 32'(wr_bus.wr_ready), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int waits;
    int at;
    en = 4'b1111;
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_ch = 2'd0;
    wr_bus.wr_pos = 8'd0;
    do_reset();

    run_to(100);
    write_pos(0, 0, waits);
    write_pos(1, 100, waits);
    run_to(300);
    write_pos(2, 200, waits);
    write_pos(3, 37, waits);
    run_frames(3);

    run_to(1);
    write_pos(0, 77, waits);
    chk("hold_wait_cycles", 32'(waits), 32'(CH));
    run_frames(2);

    run_to(20);
    set_en(1, 1'b0);
    tick();
    chk("en_drop_next_edge", 32'(pwm_out[1]), 32'd0);
    run_to(500);
    set_en(1, 1'b1);
    run_frames(2);

    run_to(200);
    write_pos(2, 10, waits);
    write_pos(2, 90, waits);
    run_frames(2);

    for (int k = 0; k < 6; k++) begin
      at = int'($urandom_range(10, 900));
      run_to(at);
      write_pos(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), waits);
      run_frames(1);
    end

    run_to(100);
    write_pos(0, 50, waits);
    run_frames(3);
    write_pos(0, 60, waits);
    run_frames(7);

    run_to(PER - 1);
    write_pos(3, 5, waits);
    run_frames(2);

    run_to(300);
    do_reset();
    run_frames(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
